// File: rtl/rv32_issue_stage.sv
// Decode-and-issue stage feeding the RV32I ALU through a registered valid/ready slot.
// Optional writeback bypass on source operands is enabled by defining RV32_ISSUE_FWD_EN.
module rv32_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [3:0]      operation,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic            out_valid_r;
    logic [XLEN-1:0] operand1_r;
    logic [XLEN-1:0] operand2_r;
    logic [3:0]      operation_r;
    logic [4:0]      out_rd_r;
    logic            out_illegal_r;

    logic            load_s;
    logic [2:0]      funct3_s;
    logic            is_shift_s;
    logic [XLEN-1:0] rs1_byp_s;
    logic [XLEN-1:0] rs2_byp_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] operand1_s;
    logic [XLEN-1:0] operand2_s;
    logic [3:0]      operation_s;
    logic [4:0]      out_rd_s;
    logic            illegal_s;

    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign in_ready = !out_valid_r || out_ready;
    assign load_s   = in_valid && in_ready;

    assign funct3_s   = instr[14:12];
    assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);
    assign imm_i_s    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u_s    = {instr[31:12], 12'd0};

`ifdef RV32_ISSUE_FWD_EN
    assign rs1_byp_s = (wb_valid && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
    assign rs2_byp_s = (wb_valid && (wb_rd == rs2_addr)) ? wb_data : rs2_data;
`else
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_valid, wb_rd, wb_data};
    assign rs1_byp_s   = rs1_data;
    assign rs2_byp_s   = rs2_data;
`endif

    // x0 reads as zero regardless of register-file data or bypass
    assign rs1_val_s = (rs1_addr == 5'd0) ? {XLEN{1'b0}} : rs1_byp_s;
    assign rs2_val_s = (rs2_addr == 5'd0) ? {XLEN{1'b0}} : rs2_byp_s;

    // Decode the instruction into ALU operands, operation code and destination
    always_comb begin
        operand1_s  = {XLEN{1'b0}};
        operand2_s  = {XLEN{1'b0}};
        operation_s = 4'b0000;
        out_rd_s    = 5'd0;
        illegal_s   = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                operand1_s = rs1_val_s;
                if (is_shift_s) begin
                    operand2_s = {27'd0, rs2_val_s[4:0]};
                end else begin
                    operand2_s = rs2_val_s;
                end
                if ((funct3_s == 3'b000) || (funct3_s == 3'b101)) begin
                    operation_s = {instr[30], funct3_s};
                end else begin
                    operation_s = {1'b0, funct3_s};
                end
                out_rd_s = instr[11:7];
            end
            OPC_OPIMM: begin
                operand1_s = rs1_val_s;
                if (is_shift_s) begin
                    operand2_s = {27'd0, instr[24:20]};
                end else begin
                    operand2_s = imm_i_s;
                end
                if (funct3_s == 3'b101) begin
                    operation_s = {instr[30], funct3_s};
                end else begin
                    operation_s = {1'b0, funct3_s};
                end
                out_rd_s = instr[11:7];
            end
            OPC_LUI: begin
                operand2_s = imm_u_s;
                out_rd_s   = instr[11:7];
            end
            OPC_AUIPC: begin
                operand1_s = pc;
                operand2_s = imm_u_s;
                out_rd_s   = instr[11:7];
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Slot occupancy: flush wins over a simultaneous load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Slot payload: captured only on an accepted, unflushed load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand1_r    <= {XLEN{1'b0}};
            operand2_r    <= {XLEN{1'b0}};
            operation_r   <= 4'b0000;
            out_rd_r      <= 5'd0;
            out_illegal_r <= 1'b0;
        end else if (load_s && !flush) begin
            operand1_r    <= operand1_s;
            operand2_r    <= operand2_s;
            operation_r   <= operation_s;
            out_rd_r      <= out_rd_s;
            out_illegal_r <= illegal_s;
        end else begin
            operand1_r    <= operand1_r;
            operand2_r    <= operand2_r;
            operation_r   <= operation_r;
            out_rd_r      <= out_rd_r;
            out_illegal_r <= out_illegal_r;
        end
    end

    assign out_valid   = out_valid_r;
    assign operand1    = operand1_r;
    assign operand2    = operand2_r;
    assign operation   = operation_r;
    assign out_rd      = out_rd_r;
    assign out_illegal = out_illegal_r;

endmodule
